// File: rtl/lif_neuron_pkg.sv
// Shared constants, FSM state encoding and weight-packing order for the LIF
// neuron and the STDP learning block that writes its weights.
package lif_neuron_pkg;

  localparam int NUM_PRE_NEURONS = 4;
  localparam int WEIGHT_W        = 4;
  localparam int MEM_W           = 8;
  localparam int WVEC_W          = NUM_PRE_NEURONS * WEIGHT_W;
  localparam int SUM_W           = 7;

  typedef enum logic [1:0] {
    ST_INTEGRATE  = 2'd0,
    ST_FIRE       = 2'd1,
    ST_REFRACTORY = 2'd2
  } state_e;

  // Neuron 0 lives in the most significant nibble of the packed weight word.
  function automatic logic [WEIGHT_W-1:0] weight_of(input logic [WVEC_W-1:0] w,
                                                    input int idx);
    return w[(NUM_PRE_NEURONS-1-idx)*WEIGHT_W +: WEIGHT_W];
  endfunction

endpackage

// File: rtl/lif_neuron_if.sv
// Stimulus/observation bundle of the LIF neuron: synaptic inputs, weight
// load path, threshold, and the registered neuron outputs.
interface lif_neuron_if;
  import lif_neuron_pkg::*;

  logic [NUM_PRE_NEURONS-1:0] pre_spike;
  logic [WVEC_W-1:0]          weight_in;
  logic                       weight_load;
  logic [MEM_W-1:0]           threshold;
  logic                       post_spike;
  logic [MEM_W-1:0]           membrane;
  logic                       refractory;
  logic [7:0]                 spike_count;

  modport master (
    output pre_spike, weight_in, weight_load, threshold,
    input  post_spike, membrane, refractory, spike_count
  );

  modport slave (
    input  pre_spike, weight_in, weight_load, threshold,
    output post_spike, membrane, refractory, spike_count
  );

endinterface

// File: rtl/lif_neuron_weighted_sum.sv
// Combinational masked sum of the four synaptic weights whose presynaptic
// spike bit is set.
module weighted_sum
  import lif_neuron_pkg::*;
(
  input  logic [WVEC_W-1:0]          weights_i,
  input  logic [NUM_PRE_NEURONS-1:0] spike_i,
  output logic [SUM_W-1:0]           sum_o
);

  always_comb begin
    sum_o = '0;
    for (int i = 0; i < NUM_PRE_NEURONS; i++) begin
      if (spike_i[i]) begin
        sum_o = sum_o + SUM_W'(weight_of(weights_i, i));
      end
    end
  end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: integrates weighted presynaptic spikes with
// shift-based leak, fires on threshold crossing, then sits out a refractory period.
module lif_neuron
  import lif_neuron_pkg::*;
#(
  parameter int REFRAC_CYCLES = 4,
  parameter int LEAK_SHIFT    = 3
) (
  input  logic         clk,
  input  logic         rst,
  lif_neuron_if.slave  bus
);

  localparam logic [3:0] REFRAC_LD = 4'(REFRAC_CYCLES);

  state_e            state_q, state_d;
  logic [MEM_W-1:0]  mem_q, mem_d;
  logic              post_q, post_d;
  logic [7:0]        spk_cnt_q, spk_cnt_d;
  logic [3:0]        rcnt_q, rcnt_d;
  logic [WVEC_W-1:0] w_q, w_d;
  logic [SUM_W-1:0]  sum;
  logic [MEM_W:0]    v_next;
  logic [MEM_W-1:0]  v_sat;

  function automatic logic [MEM_W-1:0] sat_mem(input logic [MEM_W:0] v);
    return v[MEM_W] ? {MEM_W{1'b1}} : v[MEM_W-1:0];
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  weighted_sum u_sum (
    .weights_i (w_q),
    .spike_i   (bus.pre_spike),
    .sum_o     (sum)
  );

  // One spare bit keeps membrane + sum (max 255 + 60) from wrapping before saturation.
  always_comb begin
    v_next = {1'b0, mem_q} - ({1'b0, mem_q} >> LEAK_SHIFT) + {2'b00, sum};
    v_sat  = sat_mem(v_next);
  end

  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    post_d    = 1'b0;
    rcnt_d    = rcnt_q;
    spk_cnt_d = spk_cnt_q;
    w_d       = bus.weight_load ? bus.weight_in : w_q;
    case (state_q)
      ST_INTEGRATE: begin
        if ((bus.threshold != '0) && (v_sat >= bus.threshold)) begin
          mem_d     = '0;
          post_d    = 1'b1;
          state_d   = ST_FIRE;
          spk_cnt_d = sat_inc8(spk_cnt_q);
        end else begin
          mem_d = v_sat;
        end
      end
      ST_FIRE: begin
        mem_d   = '0;
        rcnt_d  = REFRAC_LD;
        state_d = ST_REFRACTORY;
      end
      ST_REFRACTORY: begin
        mem_d  = '0;
        rcnt_d = rcnt_q - 4'd1;
        if (rcnt_q <= 4'd1) begin
          state_d = ST_INTEGRATE;
        end
      end
      default: begin
        mem_d   = '0;
        rcnt_d  = '0;
        state_d = ST_INTEGRATE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_INTEGRATE;
      mem_q     <= '0;
      post_q    <= 1'b0;
      spk_cnt_q <= '0;
      rcnt_q    <= '0;
      w_q       <= '0;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      post_q    <= post_d;
      spk_cnt_q <= spk_cnt_d;
      rcnt_q    <= rcnt_d;
      w_q       <= w_d;
    end
  end

  assign bus.post_spike  = post_q;
  assign bus.membrane    = mem_q;
  assign bus.refractory  = (state_q != ST_INTEGRATE);
  assign bus.spike_count = spk_cnt_q;

endmodule

// File: tb/tb_lif_neuron.sv
// Directed bench for lif_neuron: a behavioural neuron model checked every cycle,
// plus hand-computed membrane/spike expectations for the key scenarios.
module tb_lif_neuron;

  localparam int REFRAC = 4;
  localparam int LEAK   = 3;

  logic clk;
  logic rst;
  lif_neuron_if bus ();

  lif_neuron #(.REFRAC_CYCLES(REFRAC), .LEAK_SHIFT(LEAK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // Model state: membrane value, cycles of refractoriness still owed, spike count.
  int m_mem, m_rem, m_cnt, m_w[4];
  bit m_post;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mem = 0; m_rem = 0; m_cnt = 0; m_post = 0;
    for (int i = 0; i < 4; i++) m_w[i] = 0;
  endtask

  task automatic model_step();
    int sum, v;
    sum = 0;
    for (int i = 0; i < 4; i++) if (bus.pre_spike[i]) sum += m_w[i];
    if (m_rem > 0) begin
      m_rem--; m_mem = 0; m_post = 0;
    end else begin
      v = m_mem - m_mem / (2 ** LEAK) + sum;
      if (v > 255) v = 255;
      if (bus.threshold != 0 && v >= int'(bus.threshold)) begin
        m_mem = 0; m_post = 1; m_rem = REFRAC + 1;
        if (m_cnt < 255) m_cnt++;
      end else begin
        m_mem = v; m_post = 0;
      end
    end
    if (bus.weight_load)
      for (int i = 0; i < 4; i++) m_w[i] = int'(bus.weight_in >> (12 - 4 * i)) & 15;
  endtask

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      chk("membrane", 16'(bus.membrane), 16'(m_mem));
      chk("post_spike", 16'(bus.post_spike), 16'(m_post));
      chk("refractory", 16'(bus.refractory), 16'(m_rem > 0));
      chk("spike_count", 16'(bus.spike_count), 16'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input logic [3:0] pre, input logic [15:0] w, input logic wl,
                       input logic [7:0] thr);
    bus.pre_spike   = pre;
    bus.weight_in   = w;
    bus.weight_load = wl;
    bus.threshold   = thr;
  endtask

  int exp28[10] = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 7};
  int exp30[7]  = '{60, 113, 159, 200, 235, 255, 255};

  initial begin
    drive(4'h0, 16'h0000, 1'b0, 8'd0);
    rst = 1'b1;
    model_reset();
    #12;
    chk("rst_membrane", 16'(bus.membrane), 16'd0);
    chk("rst_post", 16'(bus.post_spike), 16'd0);
    chk("rst_refr", 16'(bus.refractory), 16'd0);
    chk("rst_count", 16'(bus.spike_count), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;

    // Weight load races with a spike: old weights (0) apply on that edge.
    drive(4'h1, 16'h8000, 1'b1, 8'd200);
    tick();
    chk("wload_same_edge", 16'(bus.membrane), 16'd0);
    drive(4'h0, 16'h0000, 1'b0, 8'd200);
    tick();
    drive(4'h1, 16'h0000, 1'b0, 8'd200);
    tick();
    chk("wload_next_pulse", 16'(bus.membrane), 16'd8);
    drive(4'h0, 16'h0000, 1'b0, 8'd200);
    repeat (3) tick();

    // Single pulse and leak decay to the floor.
    do_reset();
    drive(4'h0, 16'hF000, 1'b1, 8'd200);
    tick();
    drive(4'h1, 16'h0000, 1'b0, 8'd200);
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 0) drive(4'h0, 16'h0000, 1'b0, 8'd200);
      chk("leak_seq", 16'(bus.membrane), 16'(exp28[k]));
      chk("leak_no_spike", 16'(bus.post_spike), 16'd0);
    end

    // Threshold crossing, refractory window and re-integration.
    do_reset();
    drive(4'h0, 16'h4444, 1'b1, 8'd20);
    tick();
    drive(4'hF, 16'h0000, 1'b0, 8'd20);
    tick();
    chk("fire_e1_mem", 16'(bus.membrane), 16'd16);
    tick();
    chk("fire_e2_post", 16'(bus.post_spike), 16'd1);
    chk("fire_e2_mem", 16'(bus.membrane), 16'd0);
    chk("fire_e2_cnt", 16'(bus.spike_count), 16'd1);
    tick();
    chk("fire_e3_post", 16'(bus.post_spike), 16'd0);
    repeat (3) tick();
    chk("refr_e6", 16'(bus.refractory), 16'd1);
    tick();
    chk("refr_e7", 16'(bus.refractory), 16'd0);
    chk("refr_e7_mem", 16'(bus.membrane), 16'd0);
    tick();
    chk("reint_e8_mem", 16'(bus.membrane), 16'd16);
    tick();
    chk("reint_e9_post", 16'(bus.post_spike), 16'd1);
    chk("reint_e9_cnt", 16'(bus.spike_count), 16'd2);

    // Reset in the middle of refractory.
    do_reset();
    drive(4'h0, 16'h4444, 1'b1, 8'd20);
    tick();
    drive(4'hF, 16'h0000, 1'b0, 8'd20);
    repeat (5) tick();
    chk("pre_abort_refr", 16'(bus.refractory), 16'd1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("abort_mem", 16'(bus.membrane), 16'd0);
    chk("abort_refr", 16'(bus.refractory), 16'd0);
    chk("abort_post", 16'(bus.post_spike), 16'd0);
    chk("abort_cnt", 16'(bus.spike_count), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("abort_weights_clear", 16'(bus.membrane), 16'd0);
    drive(4'h0, 16'h4444, 1'b1, 8'd20);
    tick();
    drive(4'hF, 16'h0000, 1'b0, 8'd20);
    tick();
    chk("post_abort_e1", 16'(bus.membrane), 16'd16);
    tick();
    chk("post_abort_e2", 16'(bus.post_spike), 16'd1);

    // Threshold 0 disables firing; saturation at 255; live threshold change.
    do_reset();
    drive(4'h0, 16'hFFFF, 1'b1, 8'd0);
    tick();
    drive(4'hF, 16'h0000, 1'b0, 8'd0);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("sat_seq", 16'(bus.membrane), 16'(exp30[k]));
    end
    chk("thr0_no_count", 16'(bus.spike_count), 16'd0);
    drive(4'h0, 16'h0000, 1'b0, 8'd100);
    tick();
    chk("live_thr_fire", 16'(bus.post_spike), 16'd1);

    // Spike counter saturation.
    do_reset();
    drive(4'h0, 16'hFFFF, 1'b1, 8'd1);
    tick();
    drive(4'hF, 16'h0000, 1'b0, 8'd1);
    repeat (262 * (REFRAC + 2)) tick();
    chk("count_sat", 16'(bus.spike_count), 16'd255);

    @(negedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
